// File: rtl/regfile_sb.sv
// Register file with a per-register busy scoreboard: 2 combinational read ports, 1 write-back port, 1 issue port.
// Optional same-cycle write-back forwarding on the read ports when WB_BYPASS_EN is defined.
module regfile_sb #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = 5
) (
  input  logic            clk_i,
  input  logic            reset_ni,
  input  logic            flush_i,
  input  logic [AW-1:0]   rs1_i,
  input  logic [AW-1:0]   rs2_i,
  output logic [XLEN-1:0] rv1_o,
  output logic [XLEN-1:0] rv2_o,
  output logic            rdy1_o,
  output logic            rdy2_o,
  input  logic            iss_valid_i,
  input  logic [AW-1:0]   iss_rd_i,
  output logic            iss_ready_o,
  input  logic            we_i,
  input  logic [AW-1:0]   rd_i,
  input  logic [XLEN-1:0] wdata_i
);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic             wr_en;
  logic             iss_acc;

  assign wr_en       = we_i && (rd_i != '0);
  assign iss_ready_o = !busy_q[iss_rd_i] || (we_i && (rd_i == iss_rd_i)) || (iss_rd_i == '0);
  assign iss_acc     = iss_valid_i && iss_ready_o;

  always_comb begin
    rv1_o  = (rs1_i == '0) ? '0 : regs_q[rs1_i];
    rdy1_o = (rs1_i == '0) || !busy_q[rs1_i];
    rv2_o  = (rs2_i == '0) ? '0 : regs_q[rs2_i];
    rdy2_o = (rs2_i == '0) || !busy_q[rs2_i];
`ifdef WB_BYPASS_EN
    if (wr_en && (rd_i == rs1_i)) begin
      rv1_o  = wdata_i;
      rdy1_o = 1'b1;
    end
    if (wr_en && (rd_i == rs2_i)) begin
      rv2_o  = wdata_i;
      rdy2_o = 1'b1;
    end
`endif
  end

  // Priority: flush clears everything, then a new issue beats a same-cycle write-back.
  always_comb begin
    busy_d = busy_q;
    if (wr_en) busy_d[rd_i] = 1'b0;
    if (iss_acc && (iss_rd_i != '0)) busy_d[iss_rd_i] = 1'b1;
    if (flush_i) busy_d = '0;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      busy_q <= '0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      busy_q <= busy_d;
      if (wr_en) regs_q[rd_i] <= wdata_i;
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed scenarios plus randomized traffic against an array-based model.
// Build with +define+WB_BYPASS_EN to check the forwarding variant.
module tb_regfile_sb;

  logic        clk;
  logic        reset_n;
  logic        flush;
  logic [4:0]  rs1, rs2, iss_rd, rd;
  logic [31:0] rv1, rv2, wdata;
  logic        rdy1, rdy2, iss_valid, iss_ready, we;

  int checks = 0;
  int errors = 0;

  logic [31:0] mreg [32];
  logic [31:0] mbusy;

  regfile_sb dut (
    .clk_i(clk), .reset_ni(reset_n), .flush_i(flush),
    .rs1_i(rs1), .rs2_i(rs2), .rv1_o(rv1), .rv2_o(rv2),
    .rdy1_o(rdy1), .rdy2_o(rdy2),
    .iss_valid_i(iss_valid), .iss_rd_i(iss_rd), .iss_ready_o(iss_ready),
    .we_i(we), .rd_i(rd), .wdata_i(wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: architectural view straight from the read/issue rules
  function automatic logic [31:0] exp_rv(input logic [4:0] a);
    if (a == 0) return 32'h0;
`ifdef WB_BYPASS_EN
    if (we && rd == a) return wdata;
`endif
    return mreg[a];
  endfunction

  function automatic logic exp_rdy(input logic [4:0] a);
    if (a == 0) return 1'b1;
`ifdef WB_BYPASS_EN
    if (we && rd == a) return 1'b1;
`endif
    return !mbusy[a];
  endfunction

  function automatic logic exp_ir();
    return (iss_rd == 0) || !mbusy[iss_rd] || (we && rd == iss_rd);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) mreg[i] = 32'h0;
    mbusy = 32'h0;
  endtask

  task automatic idle_inputs();
    flush = 0; we = 0; rd = 0; wdata = 0; iss_valid = 0; iss_rd = 0;
  endtask

  // Advance one clock and apply the same update to the model; returns at the next negedge.
  task automatic tick();
    logic acc;
    acc = iss_valid && exp_ir();
    @(posedge clk);
    if (we && rd != 0) begin
      mreg[rd] = wdata;
      mbusy[rd] = 1'b0;
    end
    if (acc && iss_rd != 0) mbusy[iss_rd] = 1'b1;
    if (flush) mbusy = 32'h0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    idle_inputs(); rs1 = 5; rs2 = 8; iss_rd = 5;
    #1;
    checks++; if (rv1 !== 32'h0) begin errors++; $display("FAIL reset_rv1 got %h want %h", rv1, 32'h0); end
    checks++; if (rdy1 !== 1'b1 || rdy2 !== 1'b1) begin errors++; $display("FAIL reset_rdy got %b%b want 11", rdy1, rdy2); end
    checks++; if (iss_ready !== 1'b1) begin errors++; $display("FAIL reset_iss_ready got %b want 1", iss_ready); end
    @(negedge clk); reset_n = 1; @(negedge clk);
    we = 1; rd = 5; wdata = 32'hDEAD_BEEF; iss_valid = 1; iss_rd = 8;
    tick();
    idle_inputs();
    #1;
    checks++; if (rv1 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL pre_reset_rv1 got %h want %h", rv1, 32'hDEAD_BEEF); end
    checks++; if (rdy2 !== 1'b0) begin errors++; $display("FAIL pre_reset_rdy2 got %b want 0", rdy2); end
    #1 reset_n = 0;
    #1;
    model_clear();
    checks++; if (rv1 !== 32'h0) begin errors++; $display("FAIL async_reset_rv1 got %h want %h", rv1, 32'h0); end
    checks++; if (rdy1 !== 1'b1 || rdy2 !== 1'b1) begin errors++; $display("FAIL async_reset_rdy got %b%b want 11", rdy1, rdy2); end
    @(negedge clk); reset_n = 1; @(negedge clk);
  endtask

  task automatic test_x0();
    idle_inputs(); we = 1; rd = 0; wdata = 32'hFFFF_FFFF; iss_valid = 1; iss_rd = 0; rs1 = 0; rs2 = 0;
    #1;
    checks++; if (iss_ready !== 1'b1) begin errors++; $display("FAIL x0_iss_ready got %b want 1", iss_ready); end
    checks++; if (rv2 !== 32'h0) begin errors++; $display("FAIL x0_rv2_pre got %h want %h", rv2, 32'h0); end
    tick();
    idle_inputs(); iss_rd = 0;
    #1;
    checks++; if (rv1 !== 32'h0 || rdy1 !== 1'b1) begin errors++; $display("FAIL x0_read got %h/%b want 0/1", rv1, rdy1); end
    checks++; if (iss_ready !== 1'b1) begin errors++; $display("FAIL x0_iss_ready_after got %b want 1", iss_ready); end
  endtask

  task automatic test_scoreboard();
    idle_inputs(); iss_valid = 1; iss_rd = 7;
    tick();
    idle_inputs(); rs1 = 7; iss_rd = 7;
    #1;
    checks++; if (rdy1 !== 1'b0) begin errors++; $display("FAIL sb_rdy1_busy got %b want 0", rdy1); end
    checks++; if (iss_ready !== 1'b0) begin errors++; $display("FAIL sb_iss_ready_busy got %b want 0", iss_ready); end
    we = 1; rd = 7; wdata = 32'h1234;
    #1;
    checks++; if (iss_ready !== 1'b1) begin errors++; $display("FAIL sb_iss_ready_wb got %b want 1", iss_ready); end
    checks++; if (rv1 !== exp_rv(7) || rdy1 !== exp_rdy(7)) begin errors++; $display("FAIL sb_pre_edge got %h/%b want %h/%b", rv1, rdy1, exp_rv(7), exp_rdy(7)); end
    tick();
    idle_inputs();
    #1;
    checks++; if (rv1 !== 32'h1234 || rdy1 !== 1'b1) begin errors++; $display("FAIL sb_after_wb got %h/%b want 00001234/1", rv1, rdy1); end
  endtask

  task automatic test_collision();
    idle_inputs(); iss_valid = 1; iss_rd = 9;
    tick();
    we = 1; rd = 9; wdata = 32'hA5; iss_valid = 1; iss_rd = 9;
    #1;
    checks++; if (iss_ready !== 1'b1) begin errors++; $display("FAIL coll_iss_ready got %b want 1", iss_ready); end
    tick();
    idle_inputs(); rs1 = 9;
    #1;
    checks++; if (rv1 !== 32'hA5 || rdy1 !== 1'b0) begin errors++; $display("FAIL coll_after got %h/%b want 000000a5/0", rv1, rdy1); end
    we = 1; rd = 9; wdata = 32'h5A;
    tick();
    idle_inputs();
  endtask

  task automatic test_flush();
    logic [31:0] old3, old4;
    idle_inputs(); we = 1; rd = 3; wdata = 32'h3333; tick();
    we = 1; rd = 4; wdata = 32'h4444; tick();
    idle_inputs(); iss_valid = 1; iss_rd = 3; tick();
    iss_rd = 4; tick();
    old3 = mreg[3]; old4 = mreg[4];
    idle_inputs(); flush = 1; iss_valid = 1; iss_rd = 6;
    tick();
    idle_inputs(); rs1 = 3; rs2 = 4;
    #1;
    checks++; if (rdy1 !== 1'b1 || rdy2 !== 1'b1) begin errors++; $display("FAIL flush_rdy34 got %b%b want 11", rdy1, rdy2); end
    checks++; if (rv1 !== old3 || rv2 !== old4) begin errors++; $display("FAIL flush_data got %h/%h want %h/%h", rv1, rv2, old3, old4); end
    rs1 = 6; iss_rd = 6;
    #1;
    checks++; if (rdy1 !== 1'b1 || iss_ready !== 1'b1) begin errors++; $display("FAIL flush_x6 got %b/%b want 1/1", rdy1, iss_ready); end
  endtask

  task automatic test_bypass();
    logic [31:0] oldv;
    idle_inputs(); we = 1; rd = 12; wdata = 32'hC0DE; tick();
    oldv = mreg[12];
    idle_inputs(); iss_valid = 1; iss_rd = 12; tick();
    idle_inputs(); we = 1; rd = 12; wdata = 32'h55; rs2 = 12;
    #1;
`ifdef WB_BYPASS_EN
    checks++; if (rv2 !== 32'h55 || rdy2 !== 1'b1) begin errors++; $display("FAIL bypass_pre got %h/%b want 00000055/1", rv2, rdy2); end
`else
    checks++; if (rv2 !== oldv || rdy2 !== 1'b0) begin errors++; $display("FAIL bypass_pre got %h/%b want %h/0", rv2, rdy2, oldv); end
`endif
    tick();
    idle_inputs();
    #1;
    checks++; if (rv2 !== 32'h55 || rdy2 !== 1'b1) begin errors++; $display("FAIL bypass_post got %h/%b want 00000055/1", rv2, rdy2); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      we        = ($urandom_range(0, 99) < 40);
      rd        = 5'($urandom_range(0, 7));
      wdata     = $urandom;
      iss_valid = ($urandom_range(0, 99) < 50);
      iss_rd    = 5'($urandom_range(0, 7));
      flush     = ($urandom_range(0, 99) < 4);
      rs1       = 5'($urandom_range(0, 9));
      rs2       = 5'($urandom_range(0, 9));
      #1;
      checks++; if (rv1 !== exp_rv(rs1) || rdy1 !== exp_rdy(rs1)) begin errors++; $display("FAIL rand_port1 n=%0d rs1=%0d got %h/%b want %h/%b", n, rs1, rv1, rdy1, exp_rv(rs1), exp_rdy(rs1)); end
      checks++; if (rv2 !== exp_rv(rs2) || rdy2 !== exp_rdy(rs2)) begin errors++; $display("FAIL rand_port2 n=%0d rs2=%0d got %h/%b want %h/%b", n, rs2, rv2, rdy2, exp_rv(rs2), exp_rdy(rs2)); end
      checks++; if (iss_ready !== exp_ir()) begin errors++; $display("FAIL rand_iss_ready n=%0d iss_rd=%0d got %b want %b", n, iss_rd, iss_ready, exp_ir()); end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    reset_n = 0;
    idle_inputs(); rs1 = 0; rs2 = 0;
    model_clear();
    @(negedge clk);
    test_reset();
    test_x0();
    test_scoreboard();
    test_collision();
    test_flush();
    test_bypass();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
